// File: rtl/pipe_pkg.sv
// Shared state encoding and helpers for the pipe_stage pipeline register.
// The state value equals the number of held beats, so count needs no decode.
package pipe_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  function automatic logic [STATE_W-1:0] state_count(input state_e s);
    return STATE_W'(s);
  endfunction

endpackage

// File: rtl/pipe_stage_if.sv
// Upstream/downstream valid-ready handshake bundle for one pipeline stage.
// The slave modport is the stage itself; master is whoever drives it.
interface pipe_stage_if #(
  parameter int WIDTH = 32
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

endinterface

// File: rtl/pipe_data_reg.sv
// Load-enabled payload register with asynchronous active-low reset.
// Used for both the main (output) entry and the skid entry of pipe_stage.
module pipe_data_reg #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  always_comb begin
    data_d = load ? d : data_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) data_q <= RESET_VAL;
    else      data_q <= data_d;
  end

  assign q = data_q;

endmodule

// File: rtl/pipe_stage.sv
// Valid/ready pipeline stage with optional skid entry and synchronous flush.
// With SKID=1 in_ready depends only on registered state, breaking the ready chain.
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter bit               SKID      = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  pipe_stage_if.slave        io,
  output logic [STATE_W-1:0] count
);

  state_e           state_q;
  state_e           state_d;
  logic             accept;
  logic             deliver;
  logic             in_ready;
  logic             out_valid;
  logic             main_load;
  logic             skid_load;
  logic             main_from_skid;
  logic [WIDTH-1:0] main_in;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_EMPTY;
    else      state_q <= state_d;
  end

  // Flush overrides every handshake and leaves the payload registers untouched.
  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    skid_load      = 1'b0;
    main_from_skid = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d   = ST_ONE;
            main_load = 1'b1;
          end
        end
        ST_ONE: begin
          if (accept && deliver) begin
            main_load = 1'b1;
          end else if (accept && SKID) begin
            state_d   = ST_TWO;
            skid_load = 1'b1;
          end else if (deliver) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (deliver) begin
            state_d        = ST_ONE;
            main_load      = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    out_valid = (state_q != ST_EMPTY);
    if (SKID) in_ready = (state_q != ST_TWO);
    else      in_ready = !out_valid || io.out_ready;
    accept  = io.in_valid && in_ready;
    deliver = out_valid && io.out_ready;
  end

  assign main_in = main_from_skid ? skid_q : io.in_data;

  pipe_data_reg #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) u_main (
    .clk  (clk),
    .rst  (rst),
    .load (main_load),
    .d    (main_in),
    .q    (main_q)
  );

  generate
    if (SKID) begin : g_skid
      pipe_data_reg #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
      ) u_skid (
        .clk  (clk),
        .rst  (rst),
        .load (skid_load),
        .d    (io.in_data),
        .q    (skid_q)
      );
    end else begin : g_no_skid
      // Never selected without a skid entry; tied off to keep the mux uniform.
      logic unused_skid_load;
      assign unused_skid_load = skid_load;
      assign skid_q           = RESET_VAL;
    end
  endgenerate

  assign io.in_ready  = in_ready;
  assign io.out_valid = out_valid;
  assign io.out_data  = main_q;
  assign count        = state_count(state_q);

endmodule

// File: tb/tb_pipe_stage.sv
// Directed bench for pipe_stage: SKID=1 instance driven from a vector table,
// SKID=0 instance plus reset/flush corner cases driven by hand sequences.
module tb_pipe_stage;

  typedef struct packed {
    logic        ov;
    logic        ir;
    logic [1:0]  cnt;
    logic [31:0] data;
  } obs_t;

  typedef struct packed {
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_ready;
    logic        flush;
    obs_t        exp;
  } vec_t;

  logic       clk;
  logic       rst;
  logic       flush1;
  logic       flush0;
  logic [1:0] count1;
  logic [1:0] count0;
  int         n_vectors;
  int         n_miscompares;
  vec_t       vecs[$];

  pipe_stage_if #(.WIDTH(32)) bus1();
  pipe_stage_if #(.WIDTH(32)) bus0();

  pipe_stage #(.WIDTH(32), .RESET_VAL(32'h0), .SKID(1'b1)) dut1 (
    .clk   (clk),
    .rst   (rst),
    .flush (flush1),
    .io    (bus1.slave),
    .count (count1)
  );

  pipe_stage #(.WIDTH(32), .RESET_VAL(32'h0), .SKID(1'b0)) dut0 (
    .clk   (clk),
    .rst   (rst),
    .flush (flush0),
    .io    (bus0.slave),
    .count (count0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t mk(input logic ov, input logic ir, input logic [1:0] cnt,
                              input logic [31:0] data);
    obs_t o;
    o.ov = ov; o.ir = ir; o.cnt = cnt; o.data = data;
    return o;
  endfunction

  function automatic vec_t mkv(input logic iv, input logic [31:0] id, input logic ordy,
                               input logic fl, input obs_t exp);
    vec_t v;
    v.in_valid = iv; v.in_data = id; v.out_ready = ordy; v.flush = fl; v.exp = exp;
    return v;
  endfunction

  function automatic obs_t sample1();
    return mk(bus1.out_valid, bus1.in_ready, count1, bus1.out_data);
  endfunction

  function automatic obs_t sample0();
    return mk(bus0.out_valid, bus0.in_ready, count0, bus0.out_data);
  endfunction

  task automatic drive1(input logic iv, input logic [31:0] id, input logic ordy, input logic fl);
    bus1.in_valid = iv; bus1.in_data = id; bus1.out_ready = ordy; flush1 = fl;
  endtask

  task automatic drive0(input logic iv, input logic [31:0] id, input logic ordy, input logic fl);
    bus0.in_valid = iv; bus0.in_data = id; bus0.out_ready = ordy; flush0 = fl;
  endtask

  // Inputs change on the falling edge; registered results are sampled 1 after the rising edge.
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    drive1(v.in_valid, v.in_data, v.out_ready, v.flush);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input obs_t act, input obs_t exp);
    n_vectors++;
    if (act !== exp) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got ov=%0b ir=%0b cnt=%0d data=%h, expected ov=%0b ir=%0b cnt=%0d data=%h",
               name, act.ov, act.ir, act.cnt, act.data, exp.ov, exp.ir, exp.cnt, exp.data);
    end
  endtask

  initial begin
    n_vectors     = 0;
    n_miscompares = 0;

    // Streaming at full rate.
    vecs.push_back(mkv(1'b1, 32'd5,  1'b1, 1'b0, mk(1'b1, 1'b1, 2'd1, 32'd5)));
    vecs.push_back(mkv(1'b1, 32'd6,  1'b1, 1'b0, mk(1'b1, 1'b1, 2'd1, 32'd6)));
    vecs.push_back(mkv(1'b1, 32'd7,  1'b1, 1'b0, mk(1'b1, 1'b1, 2'd1, 32'd7)));
    vecs.push_back(mkv(1'b1, 32'd8,  1'b1, 1'b0, mk(1'b1, 1'b1, 2'd1, 32'd8)));
    vecs.push_back(mkv(1'b0, 32'd0,  1'b1, 1'b0, mk(1'b0, 1'b1, 2'd0, 32'd8)));
    // Stall fills the skid entry, then drains in order.
    vecs.push_back(mkv(1'b1, 32'd10, 1'b0, 1'b0, mk(1'b1, 1'b1, 2'd1, 32'd10)));
    vecs.push_back(mkv(1'b1, 32'd11, 1'b0, 1'b0, mk(1'b1, 1'b0, 2'd2, 32'd10)));
    vecs.push_back(mkv(1'b1, 32'd12, 1'b0, 1'b0, mk(1'b1, 1'b0, 2'd2, 32'd10)));
    vecs.push_back(mkv(1'b1, 32'd12, 1'b1, 1'b0, mk(1'b1, 1'b1, 2'd1, 32'd11)));
    vecs.push_back(mkv(1'b1, 32'd12, 1'b1, 1'b0, mk(1'b1, 1'b1, 2'd1, 32'd12)));
    vecs.push_back(mkv(1'b0, 32'd0,  1'b1, 1'b0, mk(1'b0, 1'b1, 2'd0, 32'd12)));
    // Flush while full discards held beats and the beat offered alongside it.
    vecs.push_back(mkv(1'b1, 32'd30, 1'b0, 1'b0, mk(1'b1, 1'b1, 2'd1, 32'd30)));
    vecs.push_back(mkv(1'b1, 32'd31, 1'b0, 1'b0, mk(1'b1, 1'b0, 2'd2, 32'd30)));
    vecs.push_back(mkv(1'b1, 32'd32, 1'b0, 1'b1, mk(1'b0, 1'b1, 2'd0, 32'd30)));
    vecs.push_back(mkv(1'b0, 32'd0,  1'b1, 1'b0, mk(1'b0, 1'b1, 2'd0, 32'd30)));
    vecs.push_back(mkv(1'b1, 32'd33, 1'b1, 1'b0, mk(1'b1, 1'b1, 2'd1, 32'd33)));
    vecs.push_back(mkv(1'b0, 32'd0,  1'b1, 1'b0, mk(1'b0, 1'b1, 2'd0, 32'd33)));

    // Reset held with a beat offered upstream.
    rst = 1'b0;
    drive1(1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
    drive0(1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_skid1", sample1(), mk(1'b0, 1'b1, 2'd0, 32'h0));
    checkOutput("reset_skid0", sample0(), mk(1'b0, 1'b1, 2'd0, 32'h0));

    @(negedge clk);
    rst = 1'b1;
    drive1(1'b1, 32'h1, 1'b0, 1'b0);
    drive0(1'b1, 32'h1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("first_beat_skid1", sample1(), mk(1'b1, 1'b1, 2'd1, 32'h1));
    checkOutput("first_beat_skid0", sample0(), mk(1'b1, 1'b0, 2'd1, 32'h1));

    @(negedge clk);
    drive1(1'b0, 32'h0, 1'b1, 1'b0);
    drive0(1'b0, 32'h0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("drain_skid1", sample1(), mk(1'b0, 1'b1, 2'd0, 32'h1));
    checkOutput("drain_skid0", sample0(), mk(1'b0, 1'b1, 2'd0, 32'h1));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d", i), sample1(), vecs[i].exp);
    end

    // Single-entry stage: ready follows out_ready combinationally.
    @(negedge clk);
    drive0(1'b1, 32'd20, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("noskid_hold20", sample0(), mk(1'b1, 1'b0, 2'd1, 32'd20));
    @(negedge clk);
    drive0(1'b1, 32'd99, 1'b0, 1'b0);
    #1;
    checkOutput("noskid_block_comb", sample0(), mk(1'b1, 1'b0, 2'd1, 32'd20));
    @(posedge clk);
    #1;
    checkOutput("noskid_stable20", sample0(), mk(1'b1, 1'b0, 2'd1, 32'd20));
    @(negedge clk);
    drive0(1'b1, 32'd21, 1'b1, 1'b0);
    #1;
    checkOutput("noskid_ready_comb", sample0(), mk(1'b1, 1'b1, 2'd1, 32'd20));
    @(posedge clk);
    #1;
    checkOutput("noskid_swap21", sample0(), mk(1'b1, 1'b1, 2'd1, 32'd21));
    @(negedge clk);
    drive0(1'b0, 32'd0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("noskid_empty", sample0(), mk(1'b0, 1'b1, 2'd0, 32'd21));

    // Asynchronous reset between edges while the skid stage is full.
    @(negedge clk);
    drive1(1'b1, 32'd40, 1'b0, 1'b0);
    @(negedge clk);
    drive1(1'b1, 32'd41, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("pre_reset_full", sample1(), mk(1'b1, 1'b0, 2'd2, 32'd40));
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async_reset_skid1", sample1(), mk(1'b0, 1'b1, 2'd0, 32'h0));
    checkOutput("async_reset_skid0", sample0(), mk(1'b0, 1'b1, 2'd0, 32'h0));
    @(posedge clk);
    #1;
    checkOutput("reset_held_skid1", sample1(), mk(1'b0, 1'b1, 2'd0, 32'h0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
